// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS memory stage:
// FSM state encoding, opcode constants, alignment helper.
package mem_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   function automatic logic word_aligned(input logic [1:0] lo);
      return lo == 2'b00;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Unified instruction/data memory bus with a ready handshake.
// master = memory stage, slave = memory.
interface mem_bus_ctrl_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_rd;
   logic          mem_wr;
   logic          mem_ready;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_rd,
      output mem_wr,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_rd,
      input  mem_wr,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/mem_bus_ctrl_req_fsm.sv
// Request sequencer: state, timeout counter, strobes,
// stall and sticky error for one transaction per micro-step.
module mem_req_fsm
   import mem_bus_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CW      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic MemRd,
   input  logic MemWr,
   input  logic misaligned,
   input  logic mem_ready,
   output logic mem_rd,
   output logic mem_wr,
   output logic stall,
   output logic err,
   output logic start,
   output logic load
);

   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          req;

   assign req     = MemRd | MemWr;
   assign cnt_nxt = cnt + 1'b1;
   assign start   = (state == IDLE) && req;
   assign load    = (state == BUSY) && mem_ready && mem_rd;

   always_comb begin
      stall = 1'b0;
      unique case (state)
         IDLE:    stall = req;
         BUSY:    stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (req) begin
                  if (misaligned) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     mem_rd <= MemRd & ~MemWr;
                     mem_wr <= MemWr;
                     state  <= BUSY;
                     if (MemRd & MemWr)
                        err <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  cnt    <= '0;
                  state  <= DONE;
               end else if (cnt_nxt == TMO) begin
                  // abort: the memory never answered
                  err    <= 1'b1;
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  cnt    <= '0;
                  state  <= DONE;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side stage of the multi-cycle MIPS datapath:
// address mux, IR/MDR and bus address/data registers.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15,
   parameter int CW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemRd,
   input  logic          MemWr,
   input  logic          IorD,
   input  logic          IRWr,
   input  logic [AW-1:0] PC,
   input  logic [AW-1:0] ALUOut,
   input  logic [DW-1:0] B,
   mem_bus_ctrl_if.master bus,
   output logic [DW-1:0] IR,
   output logic [DW-1:0] MDR,
   output logic [5:0]    Op,
   output logic          stall,
   output logic          err
);

   logic [AW-1:0] addr;
   logic          misaligned;
   logic          start;
   logic          load;
   logic          irwr_q;
   logic          rd_q;
   logic          wr_q;

   assign addr       = IorD ? ALUOut : PC;
   assign misaligned = ~word_aligned(addr[1:0]);
   assign bus.mem_rd = rd_q;
   assign bus.mem_wr = wr_q;
   assign Op         = IR[31:26];

   mem_req_fsm #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .MemRd      (MemRd),
      .MemWr      (MemWr),
      .misaligned (misaligned),
      .mem_ready  (bus.mem_ready),
      .mem_rd     (rd_q),
      .mem_wr     (wr_q),
      .stall      (stall),
      .err        (err),
      .start      (start),
      .load       (load)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         irwr_q        <= 1'b0;
         IR            <= '0;
         MDR           <= '0;
      end else begin
         if (start) begin
            bus.mem_addr  <= addr;
            bus.mem_wdata <= B;
            irwr_q        <= IRWr;
         end
         if (load) begin
            MDR <= bus.mem_rdata;
            if (irwr_q)
               IR <= bus.mem_rdata;
         end
      end
   end

endmodule
